// File: rtl/pipe_pkg.sv
// Shared stage-bundle widths, NOP bundle and skid FSM states
// for the inter-stage pipeline register.
package pipe_pkg;

  localparam int IF_ID_W  = 96;
  localparam int ID_EX_W  = 177;
  localparam int EX_MEM_W = 110;
  localparam int MEM_WB_W = 71;

  localparam logic [ID_EX_W-1:0] BUBBLE_NOP = '0;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } skid_st_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: WIDTH payload register plus its valid bit.
// Clear wins over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = ID_EX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // valid bit and payload capture; clear kills the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, stall and flush.
// Define PIPE_SKID_EN for the two-entry version with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = ID_EX_W,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] drop_cnt
);

  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_held;
  logic             w_drop;
  logic             w_main_ld;
  logic             w_main_clr;
  logic [WIDTH-1:0] w_main_d;
  logic             w_main_v;
  logic [WIDTH-1:0] w_main_q;
  logic [CNT_W-1:0] r_drop;

  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_ld),
    .i_clear (w_main_clr),
    .i_data  (w_main_d),
    .o_valid (w_main_v),
    .o_data  (w_main_q)
  );

`ifdef PIPE_SKID_EN

  skid_st_e         r_state;
  skid_st_e         w_state_nx;
  logic             r_in_ready;
  logic             w_skid_ld;
  logic             w_skid_clr;
  logic             w_skid_v;
  logic [WIDTH-1:0] w_skid_q;

  pipe_slot #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_ld),
    .i_clear (w_skid_clr),
    .i_data  (in_data),
    .o_valid (w_skid_v),
    .o_data  (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign w_in_acc  = in_valid & r_in_ready;
  assign w_out_acc = w_main_v & out_ready;
  assign w_held    = w_main_v | w_skid_v;

  // state and registered ready; ready low only while both slots full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_in_ready <= (w_state_nx != TWO);
    end
  end

  // next state and slot steering; skid refills main on drain
  always_comb begin
    w_state_nx = r_state;
    w_main_ld  = 1'b0;
    w_main_clr = 1'b0;
    w_skid_ld  = 1'b0;
    w_skid_clr = 1'b0;
    w_main_d   = in_data;
    if (flush) begin
      w_state_nx = EMPTY;
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_acc) begin
            w_state_nx = ONE;
            w_main_ld  = 1'b1;
          end
        end
        ONE: begin
          unique case (1'b1)
            w_in_acc & !w_out_acc: begin
              w_state_nx = TWO;
              w_skid_ld  = 1'b1;
            end
            !w_in_acc & w_out_acc: begin
              w_state_nx = EMPTY;
              w_main_clr = 1'b1;
            end
            w_in_acc & w_out_acc: begin
              w_main_ld  = 1'b1;
            end
            default: begin
              w_state_nx = ONE;
            end
          endcase
        end
        TWO: begin
          if (w_out_acc) begin
            w_state_nx = ONE;
            w_main_ld  = 1'b1;
            w_main_d   = w_skid_q;
            w_skid_clr = 1'b1;
          end
        end
        default: begin
          w_state_nx = EMPTY;
        end
      endcase
    end
  end

`else

  assign in_ready   = !w_main_v | out_ready;
  assign w_in_acc   = in_valid & in_ready;
  assign w_out_acc  = w_main_v & out_ready;
  assign w_held     = w_main_v;
  assign w_main_ld  = w_in_acc;
  assign w_main_clr = flush | (w_out_acc & !w_in_acc);
  assign w_main_d   = in_data;

`endif

  assign w_drop = flush & (w_held | w_in_acc);

  // saturating count of flushes that killed a live bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != {CNT_W{1'b1}})) begin
      r_drop <= r_drop + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = w_main_v;
  assign out_data  = w_main_v ? w_main_q : BUBBLE;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (works with or without PIPE_SKID_EN).
// Inputs change 1 time unit after posedge; the monitor samples at negedge.
module tb_pipe_stage_reg;

  localparam int W     = 177;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int exp_drop = 0;
  logic [W-1:0] q[$];

  pipe_stage_reg #(
    .WIDTH  (W),
    .BUBBLE ('0),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(output bit acc);
    #1;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      step(acc);
    end
    chk("drain_empty", W'(q.size()), '0);
  endtask

  // monitor: pops on output transfer, pushes on accepted input
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      q.delete();
      exp_drop = 0;
    end else begin
      chk("drop_cnt", W'(drop_cnt), W'(exp_drop));
      if (!out_valid) begin
        chk("bubble", out_data, '0);
        chk("latency", W'(q.size()), '0);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious: got %0h expected none at %0t",
                   out_data, $time);
        end else begin
          e = q.pop_front();
          chk("order", out_data, e);
          n_pop++;
        end
      end
      if (flush) begin
        if ((q.size() != 0) || (in_valid && in_ready)) begin
          if (exp_drop != SAT) exp_drop++;
        end
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back(in_data);
      end
    end
  end

  initial begin
    bit acc;
    int d;
    int p0;
    logic [191:0] rnd;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1;
    in_data = W'(99); out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_data", out_data, '0);
    chk("rst_drop", W'(drop_cnt), W'(0));
    chk("rst_ready", W'(in_ready), W'(1));

    // reset asserted mid-stream
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = W'(32'h11 + i);
      step(acc);
    end
    out_ready = 1'b0;
    step(acc);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_data", out_data, '0);
    chk("midrst_drop", W'(drop_cnt), W'(0));
    chk("midrst_ready", W'(in_ready), W'(1));
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    step(acc);

    // streaming 1..8
    p0 = n_pop;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      step(acc);
      chk("stream_acc", W'(acc), W'(1));
    end
    drain();
    chk("stream_cnt", W'(n_pop - p0), W'(8));

    // stall after accepting 5
    p0 = n_pop;
    out_ready = 1'b0;
    d = 5;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = W'(d);
      step(acc);
      if (acc) d++;
    end
    chk("stall_hold", out_data, W'(5));
    chk("stall_valid", W'(out_valid), W'(1));
    chk("stall_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (d > 7) break;
      in_valid = 1'b1; in_data = W'(d);
      step(acc);
      if (acc) d++;
    end
    chk("stall_fed", W'(d), W'(8));
    drain();
    chk("stall_cnt", W'(n_pop - p0), W'(3));

    // flush with live entries and an incoming bundle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'(32'hA);
    step(acc);
    in_data = W'(32'hB);
    step(acc);
    flush = 1'b1; in_data = W'(32'hC);
    step(acc);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", W'(out_valid), W'(0));
    chk("flush_data", out_data, '0);
    chk("flush_drop", W'(drop_cnt), W'(1));
    flush = 1'b1;
    step(acc);
    flush = 1'b0;
    #1;
    chk("flush_empty_drop", W'(drop_cnt), W'(1));

    // saturation: 20 flushes each killing an incoming bundle
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      flush = 1'b1; in_valid = 1'b1; in_data = W'(i + 100);
      step(acc);
    end
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("sat_drop", W'(drop_cnt), W'(15));
    in_valid = 1'b1; in_data = W'(32'h77);
    step(acc);
    in_valid = 1'b0; flush = 1'b1;
    step(acc);
    flush = 1'b0;
    #1;
    chk("sat_hold", W'(drop_cnt), W'(15));

    // random valid/ready with occasional flush
    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      flush     = ($urandom_range(0, 49) == 0);
      out_ready = flush ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rnd[W-1:0];
      step(acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
